// File: rtl/dram_cycle_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : dram_cycle_ctrl_if
// Description : CPU-side access bus of the DRAM cycle controller.
//               The CPU raises req with we/addr/wdata and holds them until
//               ack. The controller returns ack, rdata and busy.
// Ports       : (interface signals)
//               req    CPU -> ctrl   access request, held until ack
//               we     CPU -> ctrl   1 = write, 0 = read
//               addr   CPU -> ctrl   {row, column} word address
//               wdata  CPU -> ctrl   write data
//               ack    ctrl -> CPU   one-clock completion pulse
//               rdata  ctrl -> CPU   read data, valid from ack
//               busy   ctrl -> CPU   current machine cycle is not idle
// Revision    : 1.0 - initial release
// ============================================================================
interface dram_cycle_ctrl_if #(
   parameter int ROW_W  = 7,
   parameter int DATA_W = 16
) ();

   logic                req;
   logic                we;
   logic [2*ROW_W-1:0]  addr;
   logic [DATA_W-1:0]   wdata;
   logic                ack;
   logic [DATA_W-1:0]   rdata;
   logic                busy;

   // CPU side
   modport master (
      output req,
      output we,
      output addr,
      output wdata,
      input  ack,
      input  rdata,
      input  busy
   );

   // Controller side
   modport slave (
      input  req,
      input  we,
      input  addr,
      input  wdata,
      output ack,
      output rdata,
      output busy
   );

endinterface
`default_nettype wire

// File: rtl/dram_cycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dram_cycle_ctrl
// Description : DRAM cycle controller driven by the ten-phase machine cycle
//               from clocks2. At most one DRAM cycle (CPU read, CPU write,
//               RAS-only refresh, or idle) is run per machine cycle. The
//               cycle type is chosen at the phase-1 boundary, the phase
//               strobes are gated onto the DRAM pins, the row/column address
//               is multiplexed, and reads complete with a one-clock ack.
// Ports       : xtal_in      system clock, rising edge
//               init         synchronous active-high reset
//               t_num        current phase 1..10
//               t_RASn, t_CASn, t_RAM_WRn, A_stolb   phase strobes
//               cpu          CPU access bus (slave modport)
//               dram_a       multiplexed DRAM address
//               dram_rasn, dram_casn, dram_wen       DRAM strobes, active low
//               dram_dout    write data to DRAM
//               dram_doe     write-data drive enable
//               dram_din     read data from DRAM
//               refresh_row  next row to be refreshed
// Revision    : 1.0 - initial release
// ============================================================================
module dram_cycle_ctrl #(
   parameter int ROW_W       = 7,
   parameter int DATA_W      = 16,
   parameter int REFRESH_DIV = 16
) (
   input  wire                 xtal_in,
   input  wire                 init,
   input  wire  [3:0]          t_num,
   input  wire                 t_RASn,
   input  wire                 t_CASn,
   input  wire                 t_RAM_WRn,
   input  wire                 A_stolb,
   dram_cycle_ctrl_if.slave    cpu,
   output logic [ROW_W-1:0]    dram_a,
   output logic                dram_rasn,
   output logic                dram_casn,
   output logic                dram_wen,
   output logic [DATA_W-1:0]   dram_dout,
   output logic                dram_doe,
   input  wire  [DATA_W-1:0]   dram_din,
   output logic [ROW_W-1:0]    refresh_row
);

   // ------------------------------------------------------------------------
   // Constants
   // ------------------------------------------------------------------------
   localparam int                 c_CNT_W    = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(REFRESH_DIV - 1);
   localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
   localparam logic [3:0]         c_PH_FIRST = 4'd1;
   localparam logic [3:0]         c_PH_LAST  = 4'd10;

   // Machine-cycle type, held from one boundary to the next
   typedef enum logic [1:0] {
      CYC_IDLE    = 2'd0,
      CYC_ACCESS  = 2'd1,
      CYC_REFRESH = 2'd2
   } cyc_t;

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   cyc_t                 r_cyc_type;
   logic [c_CNT_W-1:0]   r_cyc_cnt;
   logic [ROW_W-1:0]     r_row;
   logic [ROW_W-1:0]     r_col;
   logic                 r_we;
   logic [DATA_W-1:0]    r_wdata;
   logic                 r_done;
   logic                 r_ack;
   logic                 r_busy;
   logic [DATA_W-1:0]    r_rdata;

   // ------------------------------------------------------------------------
   // Combinational
   // ------------------------------------------------------------------------
   cyc_t                 w_cyc_next;
   logic                 w_boundary;
   logic                 w_take;
   logic                 w_complete;
   logic [ROW_W-1:0]     w_row_eff;
   logic [ROW_W-1:0]     w_col_eff;
   logic                 w_we_eff;
   logic [DATA_W-1:0]    w_wdata_eff;
   logic [ROW_W-1:0]     w_a_nxt;
   logic                 w_rasn_nxt;
   logic                 w_casn_nxt;
   logic                 w_wen_nxt;
   logic                 w_doe_nxt;
   logic [DATA_W-1:0]    w_dout_nxt;

   assign w_boundary = (t_num == c_PH_FIRST);

   // ------------------------------------------------------------------------
   // Cycle-type FSM: state register
   // ------------------------------------------------------------------------
   always_ff @(posedge xtal_in) begin
      if (init) begin
         r_cyc_type <= CYC_IDLE;
      end else begin
         r_cyc_type <= w_cyc_next;
      end
   end

   // ------------------------------------------------------------------------
   // Cycle-type FSM: next-state decision. Outside a boundary the type is
   // simply held, which also covers phase jumps and stalls. A request is
   // refused while ack is still high so a held req cannot be served twice.
   // ------------------------------------------------------------------------
   always_comb begin
      w_cyc_next = r_cyc_type;
      w_take     = 1'b0;
      if (w_boundary) begin
         if (r_cyc_cnt == c_CNT_LAST) begin
            w_cyc_next = CYC_REFRESH;
         end else if (cpu.req && !r_ack) begin
            w_cyc_next = CYC_ACCESS;
            w_take     = 1'b1;
         end else begin
            w_cyc_next = CYC_IDLE;
         end
      end
   end

   // The boundary edge already carries the phase-1 strobes of the new cycle,
   // so pin logic works on the freshly decided type and the request fields
   // being latched on that same edge.
   assign w_row_eff   = w_take ? cpu.addr[2*ROW_W-1:ROW_W] : r_row;
   assign w_col_eff   = w_take ? cpu.addr[ROW_W-1:0]       : r_col;
   assign w_we_eff    = w_take ? cpu.we                    : r_we;
   assign w_wdata_eff = w_take ? cpu.wdata                 : r_wdata;

   // Completion happens once per access cycle, on the phase-10 edge.
   assign w_complete = (r_cyc_type == CYC_ACCESS) && (t_num == c_PH_LAST) && !r_done;

   // ------------------------------------------------------------------------
   // DRAM pin next values: strobes are gated by the cycle type, then
   // registered, giving the fixed one-clock lag behind the phase strobes.
   // ------------------------------------------------------------------------
   always_comb begin
      w_a_nxt    = dram_a;
      w_rasn_nxt = 1'b1;
      w_casn_nxt = 1'b1;
      w_wen_nxt  = 1'b1;
      w_doe_nxt  = 1'b0;
      w_dout_nxt = dram_dout;
      case (w_cyc_next)
         CYC_REFRESH: begin
            // RAS-only refresh: row strobe only, address from the refresh row
            w_a_nxt    = refresh_row;
            w_rasn_nxt = t_RASn;
         end
         CYC_ACCESS: begin
            w_a_nxt    = A_stolb ? w_col_eff : w_row_eff;
            w_rasn_nxt = t_RASn;
            w_casn_nxt = t_CASn;
            if (w_we_eff) begin
               w_wen_nxt  = t_RAM_WRn;
               w_doe_nxt  = 1'b1;
               w_dout_nxt = w_wdata_eff;
            end
         end
         default: begin
            // idle: strobes inactive, address held
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Datapath, counters and handshake
   // ------------------------------------------------------------------------
   always_ff @(posedge xtal_in) begin
      if (init) begin
         r_cyc_cnt   <= '0;
         refresh_row <= '0;
         r_row       <= '0;
         r_col       <= '0;
         r_we        <= 1'b0;
         r_wdata     <= '0;
         r_done      <= 1'b0;
         r_ack       <= 1'b0;
         r_busy      <= 1'b0;
         r_rdata     <= '0;
         dram_a      <= '0;
         dram_rasn   <= 1'b1;
         dram_casn   <= 1'b1;
         dram_wen    <= 1'b1;
         dram_doe    <= 1'b0;
         dram_dout   <= '0;
      end else begin
         if (w_boundary) begin
            r_cyc_cnt <= (r_cyc_cnt == c_CNT_LAST) ? '0 : r_cyc_cnt + c_CNT_ONE;
            r_done    <= 1'b0;
            // The refresh row advances when the refresh cycle that used it ends
            if (r_cyc_type == CYC_REFRESH) begin
               refresh_row <= refresh_row + 1'b1;
            end
         end

         if (w_take) begin
            r_row   <= w_row_eff;
            r_col   <= w_col_eff;
            r_we    <= w_we_eff;
            r_wdata <= w_wdata_eff;
         end

         r_ack  <= w_complete;
         r_busy <= (w_cyc_next != CYC_IDLE);

         if (w_complete) begin
            r_done <= 1'b1;
            if (!r_we) begin
               r_rdata <= dram_din;
            end
         end

         dram_a    <= w_a_nxt;
         dram_rasn <= w_rasn_nxt;
         dram_casn <= w_casn_nxt;
         dram_wen  <= w_wen_nxt;
         dram_doe  <= w_doe_nxt;
         dram_dout <= w_dout_nxt;
      end
   end

   assign cpu.ack   = r_ack;
   assign cpu.busy  = r_busy;
   assign cpu.rdata = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_dram_cycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_dram_cycle_ctrl
// Description : Directed self-checking bench for dram_cycle_ctrl. Emulates
//               the clocks2 phase sequence and checks reset, read, write,
//               refresh collision, refresh-row wrap and reset mid-access.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dram_cycle_ctrl;

   localparam int ROW_W       = 7;
   localparam int DATA_W      = 16;
   localparam int REFRESH_DIV = 16;

   logic               xtal_in = 1'b0;
   logic               init;
   logic [3:0]         t_num;
   logic               t_RASn, t_CASn, t_RAM_WRn, A_stolb;
   logic [ROW_W-1:0]   dram_a;
   logic               dram_rasn, dram_casn, dram_wen, dram_doe;
   logic [DATA_W-1:0]  dram_dout, dram_din;
   logic [ROW_W-1:0]   refresh_row;

   dram_cycle_ctrl_if #(.ROW_W(ROW_W), .DATA_W(DATA_W)) cpu ();

   dram_cycle_ctrl #(
      .ROW_W       (ROW_W),
      .DATA_W      (DATA_W),
      .REFRESH_DIV (REFRESH_DIV)
   ) dut (
      .xtal_in     (xtal_in),
      .init        (init),
      .t_num       (t_num),
      .t_RASn      (t_RASn),
      .t_CASn      (t_CASn),
      .t_RAM_WRn   (t_RAM_WRn),
      .A_stolb     (A_stolb),
      .cpu         (cpu),
      .dram_a      (dram_a),
      .dram_rasn   (dram_rasn),
      .dram_casn   (dram_casn),
      .dram_wen    (dram_wen),
      .dram_dout   (dram_dout),
      .dram_doe    (dram_doe),
      .dram_din    (dram_din),
      .refresh_row (refresh_row)
   );

   always #5 xtal_in = ~xtal_in;

   int               checks = 0;
   int               errors = 0;
   int               ph     = 1;
   logic [ROW_W-1:0] last_a;
   logic [DATA_W-1:0] last_rdata;

   // Phase strobe shapes of the emulated phase generator
   function automatic logic ras_of(int p);  return !(p >= 2 && p <= 8); endfunction
   function automatic logic cas_of(int p);  return !(p >= 5 && p <= 8); endfunction
   function automatic logic wr_of(int p);   return !(p >= 5 && p <= 7); endfunction
   function automatic logic astb_of(int p); return (p >= 4 && p <= 9);  endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Drive the current phase, clock one edge, sample 1 time unit later.
   task automatic tick();
      t_num     = 4'(ph);
      t_RASn    = ras_of(ph);
      t_CASn    = cas_of(ph);
      t_RAM_WRn = wr_of(ph);
      A_stolb   = astb_of(ph);
      @(posedge xtal_in);
      #1;
      ph = (ph == 10) ? 1 : ph + 1;
   endtask

   // One full machine cycle (phases 1..10) with per-edge pin checks.
   // kind: 0 idle, 1 access, 2 refresh
   task automatic run_cycle(input int kind, input logic [ROW_W-1:0] row,
                            input logic [ROW_W-1:0] col, input logic is_wr,
                            input logic [DATA_W-1:0] wd, input logic [DATA_W-1:0] din);
      logic [ROW_W-1:0] exp_a;
      dram_din = din;
      for (int p = 1; p <= 10; p++) begin
         tick();
         if (kind == 2)      exp_a = row;
         else if (kind == 1) exp_a = astb_of(p) ? col : row;
         else                exp_a = last_a;
         last_a = exp_a;
         if (kind == 1 && !is_wr && p == 10) last_rdata = din;
         check("dram_a",    32'(dram_a),    32'(exp_a));
         check("dram_rasn", 32'(dram_rasn), 32'((kind != 0) ? ras_of(p) : 1'b1));
         check("dram_casn", 32'(dram_casn), 32'((kind == 1) ? cas_of(p) : 1'b1));
         check("dram_wen",  32'(dram_wen),  32'((kind == 1 && is_wr) ? wr_of(p) : 1'b1));
         check("dram_doe",  32'(dram_doe),  32'(kind == 1 && is_wr));
         check("busy",      32'(cpu.busy),  32'(kind != 0));
         check("ack",       32'(cpu.ack),   32'(kind == 1 && p == 10));
         check("rdata",     32'(cpu.rdata), 32'(last_rdata));
         if (kind == 1 && is_wr) check("dram_dout", 32'(dram_dout), 32'(wd));
      end
   endtask

   initial begin
      cpu.req   = 1'b0;
      cpu.we    = 1'b0;
      cpu.addr  = '0;
      cpu.wdata = '0;
      dram_din  = '0;

      // ---- Reset held for 3 edges in mid-phase ----
      init = 1'b1;
      ph   = 5;
      repeat (3) tick();
      check("rst_rasn",  32'(dram_rasn),   32'd1);
      check("rst_casn",  32'(dram_casn),   32'd1);
      check("rst_wen",   32'(dram_wen),    32'd1);
      check("rst_a",     32'(dram_a),      32'd0);
      check("rst_dout",  32'(dram_dout),   32'd0);
      check("rst_doe",   32'(dram_doe),    32'd0);
      check("rst_rdata", 32'(cpu.rdata),   32'd0);
      check("rst_rrow",  32'(refresh_row), 32'd0);
      check("rst_ack",   32'(cpu.ack),     32'd0);
      check("rst_busy",  32'(cpu.busy),    32'd0);
      init       = 1'b0;
      last_a     = '0;
      last_rdata = '0;
      // remaining phases 8..10: idle, no strobes
      repeat (3) begin
         tick();
         check("post_rst_rasn", 32'(dram_rasn), 32'd1);
         check("post_rst_busy", 32'(cpu.busy),  32'd0);
      end

      // ---- Single read (boundary 1, cyc_cnt 0): row 0x35, column 0x05 ----
      cpu.req  = 1'b1;
      cpu.we   = 1'b0;
      cpu.addr = 14'h1A85;
      run_cycle(1, 7'h35, 7'h05, 1'b0, 16'h0, 16'hBEEF);
      check("read_rdata", 32'(cpu.rdata), 32'hBEEF);

      // ---- req still high while ack is 1: cycle must be idle ----
      cpu.we    = 1'b1;
      cpu.addr  = 14'h0001;
      cpu.wdata = 16'h1234;
      run_cycle(0, 7'h0, 7'h0, 1'b0, 16'h0, 16'h5555);

      // ---- Single write: row 0, column 1 ----
      run_cycle(1, 7'h00, 7'h01, 1'b1, 16'h1234, 16'h5555);
      cpu.req = 1'b0;
      check("write_keeps_rdata", 32'(cpu.rdata), 32'hBEEF);

      // ---- Idle up to the 16th boundary ----
      repeat (12) run_cycle(0, 7'h0, 7'h0, 1'b0, 16'h0, 16'h0);

      // ---- Refresh collision: request raised just before the 16th boundary ----
      cpu.req  = 1'b1;
      cpu.we   = 1'b0;
      cpu.addr = 14'h0102;
      run_cycle(2, 7'h00, 7'h0, 1'b0, 16'h0, 16'hA5A5);
      run_cycle(1, 7'h02, 7'h02, 1'b0, 16'h0, 16'hA5A5);
      cpu.req = 1'b0;
      check("collision_rdata", 32'(cpu.rdata),   32'hA5A5);
      check("rrow_after_ref0", 32'(refresh_row), 32'd1);

      // ---- Refresh row sequence 1..127 then wrap ----
      for (int r = 1; r < 128; r++) begin
         repeat ((r == 1) ? 14 : 15) run_cycle(0, 7'h0, 7'h0, 1'b0, 16'h0, 16'h0);
         run_cycle(2, 7'(r), 7'h0, 1'b0, 16'h0, 16'h0);
      end
      run_cycle(0, 7'h0, 7'h0, 1'b0, 16'h0, 16'h0);
      check("rrow_wrap", 32'(refresh_row), 32'd0);

      // ---- Reset in the middle of a read ----
      cpu.req  = 1'b1;
      cpu.we   = 1'b0;
      cpu.addr = 14'h0203;
      dram_din = 16'h7777;
      repeat (4) tick();
      check("abort_busy_before", 32'(cpu.busy),  32'd1);
      check("abort_rasn_before", 32'(dram_rasn), 32'd0);
      init = 1'b1;
      tick();
      init    = 1'b0;
      cpu.req = 1'b0;
      check("abort_rasn",  32'(dram_rasn), 32'd1);
      check("abort_casn",  32'(dram_casn), 32'd1);
      check("abort_busy",  32'(cpu.busy),  32'd0);
      check("abort_a",     32'(dram_a),    32'd0);
      check("abort_rdata", 32'(cpu.rdata), 32'd0);
      repeat (5) begin
         tick();
         check("abort_no_ack",  32'(cpu.ack),   32'd0);
         check("abort_idle_ras", 32'(dram_rasn), 32'd1);
      end
      last_a     = '0;
      last_rdata = '0;
      repeat (15) run_cycle(0, 7'h0, 7'h0, 1'b0, 16'h0, 16'h0);
      run_cycle(2, 7'h00, 7'h0, 1'b0, 16'h0, 16'h0);
      run_cycle(0, 7'h0, 7'h0, 1'b0, 16'h0, 16'h0);
      check("rrow_after_abort", 32'(refresh_row), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
